lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the data-memory port.
- Consumes the decoder's `mem_wr_en`, `byte_en` and `signed` controls, plus the ALU address and rs2 data.
- Runs a request/grant/response handshake with data memory and stalls the pipeline until the access retires.
- Performs byte-lane alignment, load sign/zero extension, misalignment detection and a response timeout.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32 for RV32I.
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ plus WAIT before the access is aborted; must be ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  execute stage holds a load/store; held stable until done_o.
- mem_wr_en_i  in  1  1 = store, 0 = load.
- byte_en_i  in  4  decoder byte enable: 0001 byte, 0011 half, 1111 word.
- signed_i  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- addr_i  in  ADDR_W  effective byte address.
- wdata_i  in  32  store data, right-justified.
- stall_o  out  1  freeze PC and pipeline registers.
- done_o  out  1  one-cycle pulse: access retired.
- rdata_o  out  32  extended load result.
- misalign_o  out  1  pulse with done_o: misaligned or illegal access.
- timeout_o  out  1  pulse with done_o: memory did not respond.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  word-aligned address, addr[1:0] = 00.
- mem_be_o  out  4  lane-shifted byte enable.
- mem_wdata_o  out  32  lane-shifted store data.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  load data valid; earliest one cycle after gnt.
- mem_rdata_i  in  32  raw word read from memory.

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset state: state = IDLE. stall_o, done_o, misalign_o, timeout_o, mem_req_o and mem_we_o are 0. mem_addr_o, mem_be_o, mem_wdata_o and rdata_o are 0. Timeout counter is 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, no request:
  - stall_o = req_valid_i (combinational), so the pipeline freezes in the same cycle the request appears.
  - mem_rvalid_i is ignored; stale or late responses are dropped.
- IDLE, accepting a request (req_valid_i = 1):
  - Latch we, offset = addr_i[1:0], byte_en_i, signed_i, the aligned address, be = byte_en_i << offset, and wdata_i << 8*offset.
  - If legal → REQ.
  - If misaligned or illegal → DONE with the err flag set; no memory access is issued.
- Misaligned/illegal conditions:
  - half access with offset[0] = 1;
  - word access with offset ≠ 00;
  - byte_en_i not one of 0001/0011/1111.
- REQ:
  - mem_req_o = 1, driven from latched registers; held stable until mem_gnt_i.
  - On gnt: store → DONE; load → WAIT.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i: capture the aligned and extended data into rdata_o → DONE.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without the awaited event → DONE with the to flag set; mem_req_o drops.
  - gnt/rvalid arriving in the same cycle as expiry wins; no timeout is flagged.
- DONE (one cycle):
  - stall_o = 0 and done_o = 1; misalign_o/timeout_o reflect the latched flags.
  - Next state is IDLE unconditionally. req_valid_i in this cycle is the same instruction and is ignored.
  - The pipeline advances at the end of this cycle.
- Load extension:
  - Shift mem_rdata_i right by 8*offset.
  - Byte: bits [7:0], extended from bit 7 if signed_i, else zero-extended.
  - Half: bits [15:0], extended from bit 15 if signed_i, else zero-extended.
  - Word: unchanged; signed_i ignored.
- rdata_o:
  - Holds its value until the next captured load.
  - Set to 0 on misalign or timeout of a load; unchanged by stores.
- Latency, zero-wait memory (gnt in the cycle of req, rvalid one cycle later):
  - load: IDLE, REQ, WAIT, DONE → stall for 3 cycles, done_o on the 4th cycle.
  - store: IDLE, REQ, DONE → done_o on the 3rd cycle.
- Reset mid-operation: immediately return to IDLE with reset output values; responses to the aborted access are dropped.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum {IDLE, REQ, WAIT, DONE};
  - constants BE_BYTE = 4'b0001, BE_HALF = 4'b0011, BE_WORD = 4'b1111;
  - function is_misaligned(byte_en, offset).
- Sub-module lsu_load_align: combinational shift and sign/zero extension of the raw read word from (offset, byte_en, signed).

Test Plan:
- LW, addr 0x104, zero-wait memory, rdata 0xDEADBEEF → mem_addr 0x104, be 1111; stall for 3 cycles; done_o on the 4th cycle; rdata_o = 0xDEADBEEF.
- LB signed, addr 0x203, rdata 0x80FF_FFFF → be 1000; rdata_o = 0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH, addr 0x302, wdata 0x0000ABCD, gnt delayed 3 cycles → mem_req_o held 4 cycles; be 1100; mem_wdata_o = 0xABCD0000; mem_we_o = 1; done_o once.
- LW, addr 0x101 → no mem_req_o; done_o and misalign_o pulse together 1 cycle after the request; rdata_o = 0.
- Load with gnt but no rvalid, TIMEOUT_CYCLES = 16 → timeout_o with done_o 16 cycles after entering REQ; a later rvalid in IDLE is ignored.
- rst_i asserted while in WAIT, rvalid arrives the cycle after release → all outputs 0; no done_o; rdata_o stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer.
// Holds the FSM states, decoder byte-enable codes and the access legality check.
package lsu_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } lsu_state_t;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Unknown byte-enable codes are treated the same as misaligned accesses.
   function automatic logic is_misaligned(input logic [3:0] byte_en, input logic [1:0] offset);
      logic bad;
      case (byte_en)
         BE_BYTE: bad = 1'b0;
         BE_HALF: bad = offset[0];
         BE_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: moves the addressed lanes down to bit 0
// and applies sign or zero extension for byte and half accesses.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [1:0]  offset_i,
   input  logic [3:0]  byte_en_i,
   input  logic        signed_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      case (byte_en_i)
         BE_BYTE: rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
         BE_HALF: rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         default: rdata_o = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory port: runs the
// req/gnt/rvalid handshake, stalls the pipeline and retires with error flags.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   input  logic              mem_wr_en_i,
   input  logic [3:0]        byte_en_i,
   input  logic              signed_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              misalign_o,
   output logic              timeout_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   lsu_state_t        state_q;
   logic              we_q;
   logic [1:0]        off_q;
   logic [3:0]        ben_q;
   logic              sgn_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              to_q;
   logic [CntW-1:0]   cnt_q;
   logic [DATA_W-1:0] load_data;
   logic              expired;

   lsu_load_align u_load_align (
      .offset_i  (off_q),
      .byte_en_i (ben_q),
      .signed_i  (sgn_q),
      .rdata_i   (mem_rdata_i),
      .rdata_o   (load_data)
   );

   assign expired = (cnt_q == CntMax);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         off_q   <= 2'b00;
         ben_q   <= 4'b0000;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  we_q    <= mem_wr_en_i;
                  off_q   <= addr_i[1:0];
                  ben_q   <= byte_en_i;
                  sgn_q   <= signed_i;
                  addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                  be_q    <= byte_en_i << addr_i[1:0];
                  wdata_q <= wdata_i << {addr_i[1:0], 3'b000};
                  to_q    <= 1'b0;
                  cnt_q   <= '0;
                  if (is_misaligned(byte_en_i, addr_i[1:0])) begin
                     err_q   <= 1'b1;
                     state_q <= StDone;
                     if (!mem_wr_en_i) rdata_q <= '0;
                  end else begin
                     err_q   <= 1'b0;
                     state_q <= StReq;
                  end
               end
            end
            StReq: begin
               cnt_q <= cnt_q + 1'b1;
               // A grant in the expiry cycle still completes the access.
               if (mem_gnt_i) begin
                  state_q <= we_q ? StDone : StWait;
               end else if (expired) begin
                  to_q    <= 1'b1;
                  state_q <= StDone;
                  if (!we_q) rdata_q <= '0;
               end
            end
            StWait: begin
               cnt_q <= cnt_q + 1'b1;
               if (mem_rvalid_i) begin
                  rdata_q <= load_data;
                  state_q <= StDone;
               end else if (expired) begin
                  to_q    <= 1'b1;
                  rdata_q <= '0;
                  state_q <= StDone;
               end
            end
            StDone: state_q <= StIdle;
         endcase
      end
   end

   assign stall_o     = (state_q == StIdle) ? req_valid_i : (state_q != StDone);
   assign done_o      = (state_q == StDone);
   assign misalign_o  = (state_q == StDone) & err_q;
   assign timeout_o   = (state_q == StDone) & to_q;
   assign mem_req_o   = (state_q == StReq);
   assign mem_we_o    = (state_q == StReq) & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: a transaction-level model predicts lane
// mapping, extension, completion cycle and error flags for each access.
module tb_lsu_ctrl;

   localparam int T = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        mem_wr_en_i;
   logic [3:0]  byte_en_i;
   logic        signed_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] rdata_o;
   logic        misalign_o;
   logic        timeout_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   logic [31:0] exp_rdata = 32'h0;

   lsu_ctrl #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .mem_wr_en_i  (mem_wr_en_i),
      .byte_en_i    (byte_en_i),
      .signed_i     (signed_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .stall_o      (stall_o),
      .done_o       (done_o),
      .rdata_o      (rdata_o),
      .misalign_o   (misalign_o),
      .timeout_o    (timeout_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // Extension computed with integer arithmetic on the selected field.
   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                            input logic [3:0] be, input logic sgn);
      longint v;
      longint field;
      field = longint'(word) / (longint'(1) << (8 * off));
      if (be == 4'b0001) begin
         v = field % 256;
         if (sgn && v >= 128) v = v - 256;
      end else if (be == 4'b0011) begin
         v = field % 65536;
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         v = field;
      end
      return v[31:0];
   endfunction

   // g: cycles in REQ before gnt (>= T means never); r: cycles in WAIT before rvalid.
   task automatic run_txn(input logic we, input logic [3:0] be, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] word, input int g, input int r,
                          input bit drop_rv);
      logic [1:0]  off;
      bit          legal;
      bit          to;
      int          ev;
      int          exp_done;
      int          req_end;
      logic [31:0] exp_be;
      off   = addr[1:0];
      legal = (be == 4'b0001) || (be == 4'b0011 && off[0] == 1'b0) ||
              (be == 4'b1111 && off == 2'b00);
      if (g >= T)       ev = 1000;
      else if (we)      ev = g;
      else if (drop_rv) ev = 1000;
      else              ev = g + 1 + r;
      to       = legal && (ev > T - 1);
      exp_done = !legal ? 1 : (to ? T + 1 : ev + 2);
      req_end  = !legal ? 0 : ((g <= T - 1) ? g + 1 : T);
      exp_be   = 32'((be * (1 << off)) % 16);

      req_valid_i  = 1'b1;
      mem_wr_en_i  = we;
      byte_en_i    = be;
      signed_i     = sgn;
      addr_i       = addr;
      wdata_i      = wdata;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      #1;
      check_eq("stall_on_request", 32'(stall_o), 32'd1);

      if (!we) begin
         if (!legal || to) exp_rdata = 32'h0;
         else              exp_rdata = ref_load(word, off, be, sgn);
      end

      for (int k = 1; k <= exp_done; k++) begin
         @(posedge clk_i);
         #1;
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = $urandom;
         check_eq("done", 32'(done_o), 32'(k == exp_done));
         check_eq("stall", 32'(stall_o), 32'(k != exp_done));
         check_eq("mem_req", 32'(mem_req_o), 32'(k <= req_end));
         if (k <= req_end) begin
            check_eq("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
            check_eq("mem_be", 32'(mem_be_o), exp_be);
            check_eq("mem_we", 32'(mem_we_o), 32'(we));
            if (we) check_eq("mem_wdata", mem_wdata_o, 32'(longint'(wdata) * (longint'(1) << (8 * off))));
         end
         if (k == exp_done) begin
            check_eq("misalign", 32'(misalign_o), 32'(!legal));
            check_eq("timeout", 32'(timeout_o), 32'(to));
            check_eq("rdata", rdata_o, exp_rdata);
            req_valid_i = 1'b0;
         end
         if (k <= req_end && k - 1 == g) mem_gnt_i = 1'b1;
         if (!we && legal && !drop_rv && g <= T - 1 && k == g + 2 + r) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = word;
         end
      end

      // Back in IDLE: a stray response must be dropped.
      @(posedge clk_i);
      #1;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
      check_eq("idle_done", 32'(done_o), 32'd0);
      check_eq("idle_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      check_eq("idle_rdata_hold", rdata_o, exp_rdata);
      check_eq("idle_done2", 32'(done_o), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
      check_eq({tag, "_done"}, 32'(done_o), 32'd0);
      check_eq({tag, "_misalign"}, 32'(misalign_o), 32'd0);
      check_eq({tag, "_timeout"}, 32'(timeout_o), 32'd0);
      check_eq({tag, "_req"}, 32'(mem_req_o), 32'd0);
      check_eq({tag, "_we"}, 32'(mem_we_o), 32'd0);
      check_eq({tag, "_addr"}, mem_addr_o, 32'd0);
      check_eq({tag, "_be"}, 32'(mem_be_o), 32'd0);
      check_eq({tag, "_wdata"}, mem_wdata_o, 32'd0);
      check_eq({tag, "_rdata"}, rdata_o, 32'd0);
   endtask

   initial begin
      logic [3:0] be;
      int         pick;
      rst_i        = 1'b1;
      req_valid_i  = 1'b0;
      mem_wr_en_i  = 1'b0;
      byte_en_i    = 4'b0000;
      signed_i     = 1'b0;
      addr_i       = 32'h0;
      wdata_i      = 32'h0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      repeat (2) @(posedge clk_i);
      #1;
      check_all_zero("reset");
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      run_txn(1'b0, 4'b1111, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
      run_txn(1'b0, 4'b0001, 1'b1, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
      run_txn(1'b0, 4'b0001, 1'b0, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
      run_txn(1'b1, 4'b0011, 1'b0, 32'h302, 32'h0000ABCD, 32'h0, 3, 0, 1'b0);
      run_txn(1'b0, 4'b1111, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
      run_txn(1'b0, 4'b0011, 1'b1, 32'h402, 32'h0, 32'h8001_7FFF, 1, 2, 1'b0);
      run_txn(1'b0, 4'b1111, 1'b0, 32'h500, 32'h0, 32'h1234_5678, 0, 0, 1'b1);
      run_txn(1'b0, 4'b1111, 1'b0, 32'h600, 32'h0, 32'hCAFE_F00D, 0, T - 2, 1'b0);
      run_txn(1'b1, 4'b1111, 1'b0, 32'h700, 32'h1111_2222, 32'h0, T - 1, 0, 1'b0);
      run_txn(1'b1, 4'b0001, 1'b0, 32'h701, 32'h0000_00A5, 32'h0, T, 0, 1'b0);

      // Reset while in WAIT; the late response must not retire anything.
      run_txn(1'b0, 4'b1111, 1'b0, 32'h800, 32'h0, 32'h5555_AAAA, 0, 0, 1'b0);
      req_valid_i = 1'b1;
      mem_wr_en_i = 1'b0;
      byte_en_i   = 4'b1111;
      addr_i      = 32'h104;
      @(posedge clk_i);
      #1;
      mem_gnt_i = 1'b1;
      @(posedge clk_i);
      #1;
      mem_gnt_i   = 1'b0;
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      check_all_zero("mid_reset");
      rst_i        = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEADBEEF;
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      check_eq("post_reset_done", 32'(done_o), 32'd0);
      check_eq("post_reset_rdata", rdata_o, 32'd0);
      exp_rdata = 32'h0;

      for (int i = 0; i < 40; i++) begin
         pick = int'($urandom_range(0, 9));
         if (pick < 3)      be = 4'b0001;
         else if (pick < 6) be = 4'b0011;
         else if (pick < 9) be = 4'b1111;
         else               be = 4'($urandom_range(0, 15));
         run_txn(1'($urandom_range(0, 1)), be, 1'($urandom_range(0, 1)), $urandom, $urandom,
                 $urandom, ($urandom_range(0, 9) == 0) ? T + 4 : int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 12)), $urandom_range(0, 9) == 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
